bram_cfg_loader: RTL
====================

Name: bram_cfg_loader

Overview:
Downstream consumer of the 32-bit configuration block RAM. On a start request it streams a contiguous run of words out of the BRAM read port and serialises them MSB-first onto the eFPGA configuration shift chain. After the last bit it issues a one-cycle latch strobe and then a done pulse. The loader drives only the BRAM address; write-port muxing (we/din) lives outside this block.

Parameters:
ADDR_W, 10, BRAM address width; equals the BRAM's addrW.
WORD_W, 32, BRAM word width; fixed at 32 and must match the BRAM data width.
CNT_W, ADDR_W+1, width of word_count; allows a full 2**ADDR_W-word load.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset is asynchronous and active-low
start  input  1  load request, sampled only in IDLE
abort  input  1  synchronous cancel, honoured in any non-IDLE state
base_addr  input  ADDR_W  first BRAM word address, captured on start
word_count  input  CNT_W  number of words to send, captured on start
bram_addr  output  ADDR_W  registered BRAM read address
bram_dout  input  WORD_W  BRAM read data, valid 1 cycle after address
cfg_bit  output  1  serial config data, = shreg[WORD_W-1]
cfg_shift_en  output  1  chain shift enable, high only in SHIFT
cfg_latch  output  1  one-cycle chain latch strobe
busy  output  1  high from the first cycle after start through LATCH
done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: bram_addr=0, shreg=0 (cfg_bit=0), cfg_shift_en=0, cfg_latch=0, busy=0, done=0, state=IDLE.
- An rst_n assertion mid-load drops all outputs immediately. No latch or done is issued.
- States: IDLE, WAIT, LOAD, SHIFT, LATCH.
- IDLE: on start=1 with word_count!=0:
  - bram_addr<=base_addr; remaining<=word_count; go to WAIT.
- IDLE: on start=1 with word_count==0:
  - stay in IDLE; done=1 next cycle; no shift, no latch.
- WAIT: one cycle to absorb BRAM read latency; go to LOAD.
- LOAD: on exit edge:
  - shreg<=bram_dout; bram_addr<=bram_addr+1; remaining<=remaining-1; bit_cnt<=0; go to SHIFT.
- SHIFT: cfg_shift_en=1 every cycle; shreg shifts left by one each cycle.
  - On bit_cnt==WORD_W-1 with remaining!=0: shreg<=bram_dout (prefetched word); bram_addr++; remaining--; bit_cnt<=0; stay in SHIFT. Words stream back-to-back with no gap cycles.
  - On bit_cnt==WORD_W-1 with remaining==0: go to LATCH.
- LATCH: cfg_latch=1, cfg_shift_en=0; go to IDLE with done=1 in the following cycle.
- Timing with start sampled at the end of cycle 0:
  - WAIT = cycle 1, LOAD = cycle 2.
  - SHIFT = cycles 3 .. 2+32N; LATCH = cycle 3+32N; done = cycle 4+32N.
- bram_addr wraps modulo 2**ADDR_W (addr 2**ADDR_W-1 is followed by 0).
- start while busy is ignored.
- abort (any non-IDLE state) forces IDLE on the next edge:
  - cfg_shift_en, cfg_latch, busy go low that cycle; done is not pulsed.
  - shreg and bram_addr hold their values.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- The BRAM contents must not be written while busy; the prefetch assumes bram_dout is stable for a fixed address.

Decomposition:
- Package cfg_loader_pkg: state enum (IDLE, WAIT, LOAD, SHIFT, LATCH) and the WORD_W=32 constant.
- One sub-module, cfg_piso: WORD_W-bit parallel-in/serial-out register with 5-bit bit counter.
  - Inputs: load, shift, din. Outputs: msb, last_bit.
- The FSM, address counter and remaining counter stay in the top.

Test Plan:
- BRAM[4]=0xA5A5_0F0F, start, base=4, count=1 -> cfg_shift_en high cycles 3-34; cfg_bit sequence 1,0,1,0,0,1,0,1,...,1,1,1,1; cfg_latch in cycle 35; done in cycle 36; busy low in cycle 36.
- BRAM[0..2]=0xFFFF_FFFF, 0x0000_0000, 0x8000_0001, count=3 -> 96 contiguous shift cycles with no gap; bit 64=1, bit 95=1; bram_addr ends at 3.
- base=1023, count=2, ADDR_W=10 -> words from addresses 1023 then 0; bram_addr wraps to 1 at end.
- count=0 -> no cfg_shift_en, no cfg_latch; done in cycle 1; busy stays 0.
- abort asserted in cycle 20 of a 2-word load -> cfg_shift_en low from cycle 21; no latch, no done; a new start afterwards completes normally.
- rst_n pulsed low mid-SHIFT, and start pulsed while busy -> all outputs 0 asynchronously on reset; start while busy causes no restart and no change to bram_addr.

Source files
------------

// File: rtl/bram_cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_pkg
//   Shared definitions for the BRAM configuration loader:
//   - WORD_W     : BRAM / configuration word width (fixed at 32)
//   - BIT_CNT_W  : width of the per-word bit counter
//   - state_t    : loader FSM states
//   - addr_inc   : BRAM address increment that wraps modulo 2**ADDR_W
// ---------------------------------------------------------------------------
package cfg_loader_pkg;

  localparam int WORD_W    = 32;
  localparam int BIT_CNT_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    LATCH = 3'd4
  } state_t;

  // Address advance for a 10-bit BRAM port; the carry out of the top bit
  // is dropped so the last address is followed by address 0.
  function automatic logic [9:0] addr_inc(input logic [9:0] a);
    return a + 10'd1;
  endfunction

endpackage

// File: rtl/bram_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// bram_cfg_loader_if
//   Groups the loader's control, BRAM read-port and configuration-chain
//   signals.
//   Control : start, abort, base_addr, word_count  (into loader)
//             busy, done                          (out of loader)
//   BRAM    : bram_addr (out), bram_dout (in, valid one cycle after addr)
//   Chain   : cfg_bit, cfg_shift_en, cfg_latch    (out of loader)
//   Modports: slave  = the loader itself
//             master = whoever drives control and models the BRAM
// ---------------------------------------------------------------------------
interface bram_cfg_loader_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32,
  parameter int CNT_W  = ADDR_W + 1
);
  import cfg_loader_pkg::*;

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [ADDR_W-1:0] bram_addr;
  logic [WORD_W-1:0] bram_dout;
  logic              cfg_bit;
  logic              cfg_shift_en;
  logic              cfg_latch;
  logic              busy;
  logic              done;

  modport slave (
    input  start, abort, base_addr, word_count, bram_dout,
    output bram_addr, cfg_bit, cfg_shift_en, cfg_latch, busy, done
  );

  modport master (
    output start, abort, base_addr, word_count, bram_dout,
    input  bram_addr, cfg_bit, cfg_shift_en, cfg_latch, busy, done
  );

endinterface

// File: rtl/bram_cfg_loader_piso.sv
// ---------------------------------------------------------------------------
// cfg_piso
//   WORD_W-bit parallel-in / serial-out shift register with a bit counter.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : capture din, restart the bit counter (has priority)
//     shift      : shift left by one, advance the bit counter
//     din        : parallel word
//     msb        : current serial bit (top of the register)
//     last_bit   : the bit on msb is the final bit of the current word
// ---------------------------------------------------------------------------
module cfg_piso #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb,
  output logic              last_bit
);
  import cfg_loader_pkg::*;

  localparam int BIT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] r_shreg;
  logic [BIT_W-1:0]  r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (load) begin
      r_shreg   <= din;
      r_bit_cnt <= '0;
    end else if (shift) begin
      r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  assign msb      = r_shreg[WORD_W-1];
  assign last_bit = (r_bit_cnt == BIT_W'(WORD_W - 1));

endmodule

// File: rtl/bram_cfg_loader.sv
// ---------------------------------------------------------------------------
// bram_cfg_loader
//   Streams word_count consecutive words from a synchronous-read BRAM,
//   starting at base_addr, MSB-first onto the configuration shift chain,
//   then pulses cfg_latch for one cycle and done the cycle after.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : bram_cfg_loader_if.slave
//             start/abort/base_addr/word_count in, busy/done out,
//             bram_addr out / bram_dout in, cfg_bit/cfg_shift_en/cfg_latch out
//   Timeline for an N-word load (start seen at the end of cycle 0):
//     WAIT 1, LOAD 2, SHIFT 3..2+32N, LATCH 3+32N, done 4+32N.
// ---------------------------------------------------------------------------
module bram_cfg_loader #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = cfg_loader_pkg::WORD_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bram_cfg_loader_if.slave     bus
);
  import cfg_loader_pkg::*;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_done;

  logic              w_capture;   // IDLE accepts a non-empty request
  logic              w_advance;   // a word leaves bram_dout for the shreg
  logic              w_piso_load;
  logic              w_piso_shift;
  logic              w_done_nxt;
  logic              w_msb;
  logic              w_last_bit;
  logic              w_more;

  assign w_more = (r_remaining != '0);

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_piso_load  = 1'b0;
    w_piso_shift = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.word_count != '0) begin
            w_capture = 1'b1;
            w_next    = WAIT;
          end else begin
            // Empty request completes immediately without touching the chain.
            w_done_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        // bram_addr was registered on the start edge; data appears next cycle.
        w_next = LOAD;
      end
      LOAD: begin
        w_piso_load = 1'b1;
        w_advance   = 1'b1;
        w_next      = SHIFT;
      end
      SHIFT: begin
        if (w_last_bit && w_more) begin
          // bram_dout already holds the next word: bram_addr moved on at the
          // previous word load, so the read latency is hidden by the shift.
          w_piso_load = 1'b1;
          w_advance   = 1'b1;
        end else begin
          w_piso_shift = 1'b1;
          if (w_last_bit) begin
            w_next = LATCH;
          end
        end
      end
      LATCH: begin
        w_next     = IDLE;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // Abort freezes shreg and bram_addr and drops straight to IDLE.
    if (bus.abort && (r_state != IDLE)) begin
      w_next       = IDLE;
      w_advance    = 1'b0;
      w_piso_load  = 1'b0;
      w_piso_shift = 1'b0;
      w_done_nxt   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State, address, remaining-word counter and done pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_capture) begin
      r_addr      <= bus.base_addr;
      r_remaining <= bus.word_count;
    end else if (w_advance) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Serialiser
  // -------------------------------------------------------------------------
  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_piso_load),
    .shift    (w_piso_shift),
    .din      (bus.bram_dout),
    .msb      (w_msb),
    .last_bit (w_last_bit)
  );

  assign bus.bram_addr    = r_addr;
  assign bus.cfg_bit      = w_msb;
  assign bus.cfg_shift_en = (r_state == SHIFT);
  assign bus.cfg_latch    = (r_state == LATCH);
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;

endmodule
